// File: rtl/mant_div.sv
// Iterative radix-2 restoring mantissa divider: quotient MSB-first, one bit per clock.
// Optional early termination on an exact remainder: define MANT_DIV_EARLY_TERM_EN.
module mant_div #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned Q_W    = 26
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [MANT_W-1:0] in_dividend,
  input  logic [MANT_W-1:0] in_divisor,
  output logic              out_busy,
  output logic              out_valid,
  output logic [Q_W-1:0]    out_quotient,
  output logic              out_sticky,
  output logic              out_div_by_zero
);

  localparam int unsigned CNT_W = $clog2(Q_W);
  localparam int unsigned REM_W = MANT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              dbz_q, dbz_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              q_bit;
  logic [REM_W-1:0]  rem_nxt;
  logic [Q_W-1:0]    quo_shift;

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, restoring step and output register inputs
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    valid_d  = 1'b0;

    q_bit     = (rem_q >= {1'b0, div_q});
    rem_nxt   = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
    quo_shift = {quo_q[Q_W-2:0], q_bit};

    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          if (in_divisor != '0) begin
            div_d    = in_divisor;
            rem_d    = {1'b0, in_dividend};
            quo_d    = '0;
            cnt_d    = CNT_W'(Q_W - 1);
            sticky_d = 1'b0;
            dbz_d    = 1'b0;
            state_d  = S_BUSY;
          end else begin
            quo_d    = '1;
            sticky_d = 1'b1;
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        // R < 2B keeps the shifted remainder inside REM_W bits
        rem_d = rem_nxt << 1;
        quo_d = quo_shift;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`ifdef MANT_DIV_EARLY_TERM_EN
        if (rem_nxt == '0) begin
          quo_d   = quo_shift << cnt_q;
          cnt_d   = '0;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        valid_d = 1'b1;
        if (!dbz_q) begin
          sticky_d = (rem_q != '0);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BUSY);
  end

  assign out_busy        = busy_q;
  assign out_valid       = valid_q;
  assign out_quotient    = quo_q;
  assign out_sticky      = sticky_q;
  assign out_div_by_zero = dbz_q;

endmodule
